// File: rtl/sr_pkg.sv
// Shared excitation codes and FSM encoding for the SR flip-flop command driver.
package sr_pkg;

  localparam logic [1:0] SR_HOLD    = 2'b00;
  localparam logic [1:0] SR_RESET   = 2'b01;
  localparam logic [1:0] SR_SET     = 2'b10;
  localparam logic [1:0] SR_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_CHECK = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

endpackage

// File: rtl/sr_cmd_fifo.sv
// Synchronous command FIFO; storage is not reset, only the pointers are.
module sr_cmd_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/sr_cmd_driver.sv
// Drives SR excitation from a queued stream of target-bit commands and
// monitors the flip-flop feedback against a shadow of the commanded value.
module sr_cmd_driver
  import sr_pkg::*;
#(
  parameter int HOLD_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_target,
  input  logic [HOLD_W-1:0] in_hold,
  output logic [1:0]        sr,
  input  logic              q_fb,
  output logic              shadow_q,
  output logic              busy,
  output logic              err
);

  localparam int CMD_W = 1 + HOLD_W;

  logic [CMD_W-1:0]  fifo_din;
  logic [CMD_W-1:0]  fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              pop_tgt;
  logic [HOLD_W-1:0] pop_hold;

  state_t            state_q;
  state_t            state_d;
  logic [HOLD_W-1:0] cnt_q;
  logic [HOLD_W-1:0] cnt_d;
  logic              cur_tgt_q;
  logic [HOLD_W-1:0] cur_hold_q;
  logic              known_q;
  logic              shadow_r;
  logic              err_r;
  logic [1:0]        sr_q;
  logic [1:0]        sr_d;
  logic              leave;
  logic              monitor;

  function automatic logic [1:0] excite(input logic tgt, input logic known, input logic cur);
    logic [1:0] code;
    if (known && (tgt == cur)) code = SR_HOLD;
    else                       code = tgt ? SR_SET : SR_RESET;
    if (code == SR_ILLEGAL) code = SR_HOLD;
    return code;
  endfunction

  assign push               = in_valid & ~fifo_full;
  assign in_ready           = ~fifo_full;
  assign fifo_din           = {in_target, in_hold};
  assign {pop_tgt, pop_hold} = fifo_dout;

  sr_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign monitor = (state_q == ST_CHECK) || (state_q == ST_HOLD);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    leave   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ST_APPLY;
        end
      end
      ST_APPLY: state_d = ST_CHECK;
      ST_CHECK: begin
        if (cur_hold_q != '0) begin
          cnt_d   = cur_hold_q;
          state_d = ST_HOLD;
        end else begin
          leave = 1'b1;
        end
      end
      ST_HOLD: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= HOLD_W'(1)) leave = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    // Chaining straight into the next command avoids an IDLE bubble.
    if (leave) begin
      if (!fifo_empty) begin
        pop     = 1'b1;
        state_d = ST_APPLY;
      end else begin
        state_d = ST_IDLE;
      end
    end
    sr_d = pop ? excite(pop_tgt, known_q, shadow_r) : SR_HOLD;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      sr_q     <= SR_HOLD;
      shadow_r <= 1'b0;
      known_q  <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      if (state_q == ST_APPLY) begin
        shadow_r <= cur_tgt_q;
        known_q  <= 1'b1;
      end
      if (monitor && (q_fb != shadow_r)) err_r <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (pop) begin
      cur_tgt_q  <= pop_tgt;
      cur_hold_q <= pop_hold;
    end
  end

  assign sr       = sr_q;
  assign shadow_q = shadow_r;
  assign err      = err_r;
  assign busy     = (state_q != ST_IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_sr_cmd_driver.sv
// Bench for sr_cmd_driver: schedule-based command model plus directed scenarios.
module tb_sr_cmd_driver;

  localparam int HOLD_W = 4;
  localparam int DEPTH  = 4;
  localparam int MAXC   = 4096;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic              in_target;
  logic [HOLD_W-1:0] in_hold;
  logic [1:0]        sr;
  logic              q_fb;
  logic              shadow_q;
  logic              busy;
  logic              err;

  logic q_ff = 1'b0;
  logic stuck;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  sr_cmd_driver #(.HOLD_W(HOLD_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_target (in_target),
    .in_hold   (in_hold),
    .sr        (sr),
    .q_fb      (q_fb),
    .shadow_q  (shadow_q),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Downstream SR flip-flop
  always @(posedge clk) begin
    if (sr == 2'b10)      q_ff <= 1'b1;
    else if (sr == 2'b01) q_ff <= 1'b0;
  end
  assign q_fb = stuck ? 1'b0 : q_ff;

  // Command schedule model: each accepted command gets a start edge s
  // (APPLY cycle follows edge s) and an end edge s+2+hold.
  int         cyc;
  int         m_s    [MAXC];
  int         m_end  [MAXC];
  bit         m_tgt  [MAXC];
  logic [1:0] m_code [MAXC];
  int         m_n, m_first, m_free;
  bit         m_err;

  function automatic int lo_idx();
    int l = m_n - (DEPTH + 4);
    if (l < m_first) l = m_first;
    return l;
  endfunction

  function automatic int pending_at(int c);
    int p = 0;
    for (int i = lo_idx(); i < m_n; i++) if (m_s[i] > c) p++;
    return p;
  endfunction

  function automatic logic [1:0] exp_sr(int c);
    for (int i = lo_idx(); i < m_n; i++) if (m_s[i] == c) return m_code[i];
    return 2'b00;
  endfunction

  function automatic logic exp_shadow(int c);
    for (int i = m_n - 1; i >= m_first; i--) if (m_s[i] + 1 <= c) return m_tgt[i];
    return 1'b0;
  endfunction

  function automatic logic exp_busy(int c);
    return (m_n > m_first) && (m_end[m_n-1] > c);
  endfunction

  initial begin
    int s;
    cyc = 0; m_n = 0; m_first = 0; m_free = 0; m_err = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_first = m_n;
        m_free  = 0;
        m_err   = 0;
      end else begin
        cyc++;
        for (int i = lo_idx(); i < m_n; i++)
          if (cyc >= m_s[i] + 2 && cyc <= m_end[i] && q_fb !== m_tgt[i]) m_err = 1;
        if (in_valid === 1'b1 && pending_at(cyc - 1) < DEPTH) begin
          s = (cyc + 1 > m_free) ? cyc + 1 : m_free;
          m_s[m_n]   = s;
          m_end[m_n] = s + 2 + int'(in_hold);
          m_tgt[m_n] = in_target;
          if (m_n > m_first && m_tgt[m_n-1] == in_target) m_code[m_n] = 2'b00;
          else m_code[m_n] = in_target ? 2'b10 : 2'b01;
          m_free = m_end[m_n];
          m_n++;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=event at %0t", nm, $time);
  endtask

  // Per-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("sr", sr, exp_sr(cyc));
        chk("sr_legal", sr == 2'b11, 0);
        chk("shadow_q", shadow_q, exp_shadow(cyc));
        chk("busy", busy, exp_busy(cyc));
        chk("in_ready", in_ready, pending_at(cyc) < DEPTH);
        chk("err", err, m_err);
      end
    end
  end

  logic [1:0] sr_log[$];
  bit         log_en = 0;
  initial forever begin
    @(negedge clk);
    if (log_en) sr_log.push_back(sr);
  end

  task automatic push(input logic t, input logic [HOLD_W-1:0] h);
    int   w = 0;
    logic acc;
    in_valid = 1'b1; in_target = t; in_hold = h;
    forever begin
      acc = in_ready;
      @(posedge clk);
      if (acc) break;
      w++;
      if (w > 100) begin timeout("push"); break; end
      @(negedge clk); #2;
    end
    @(negedge clk); #2;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int w = 0;
    while (busy !== 1'b0) begin
      @(negedge clk); #2;
      w++;
      if (w > bound) begin timeout("wait_idle"); break; end
    end
  endtask

  task automatic do_reset();
    @(negedge clk); #2;
    rst_n = 1'b0;
    @(negedge clk); @(negedge clk); #2;
    stuck = 1'b0;
    rst_n = 1'b1;
    @(negedge clk); #2;
  endtask

  initial begin
    logic [1:0] exp2 [8];
    int         i0;
    exp2 = '{2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00};
    in_valid = 0; in_target = 0; in_hold = '0; stuck = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 chk_en = 1;
    @(negedge clk); @(negedge clk); #2;
    chk("rst_sr", sr, 2'b00);
    chk("rst_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_shadow", shadow_q, 0);
    rst_n = 1'b1;
    @(negedge clk); #2;

    // Single SET command
    push(1'b1, 4'd0);
    @(negedge clk); chk("t1_sr_set", sr, 2'b10);
    @(negedge clk); chk("t1_sr_after", sr, 2'b00);
    @(negedge clk);
    chk("t1_busy", busy, 0);
    chk("t1_qfb", q_fb, 1);
    chk("t1_err", err, 0);
    chk("t1_shadow", shadow_q, 1);
    #2;

    // Back-to-back with a redundant command
    do_reset();
    sr_log.delete();
    log_en = 1;
    push(1'b1, 4'd0);
    push(1'b1, 4'd0);
    push(1'b0, 4'd2);
    wait_idle(50);
    repeat (2) @(negedge clk);
    #2;
    log_en = 0;
    i0 = -1;
    foreach (sr_log[k]) if (i0 < 0 && sr_log[k] != 2'b00) i0 = k;
    if (i0 < 0 || sr_log.size() < i0 + 8) timeout("t2_seq");
    else for (int k = 0; k < 8; k++) chk($sformatf("t2_sr%0d", k), sr_log[i0+k], exp2[k]);
    chk("t2_shadow", shadow_q, 0);

    // FIFO fills while stalled in a long hold
    do_reset();
    push(1'b1, 4'd15);
    @(negedge clk); @(negedge clk); #2;
    for (int k = 0; k < 6; k++) begin
      push(k[0], 4'd0);
      if (k == 3) chk("t3_full", in_ready, 0);
    end
    wait_idle(100);
    chk("t3_shadow", shadow_q, 1);
    chk("t3_err", err, 0);

    // Stuck feedback sets sticky err
    do_reset();
    stuck = 1'b1;
    push(1'b1, 4'd3);
    @(negedge clk); chk("t4_err_apply", err, 0);
    @(negedge clk); chk("t4_err_check", err, 0);
    @(negedge clk); chk("t4_err_rise", err, 1);
    #2;
    wait_idle(50);
    repeat (3) @(negedge clk);
    chk("t4_err_sticky", err, 1);
    chk("t4_busy", busy, 0);
    #2;
    do_reset();
    chk("t4_err_cleared", err, 0);

    // Reset during HOLD with a queue behind it
    push(1'b1, 4'd15);
    push(1'b0, 4'd0);
    push(1'b1, 4'd0);
    push(1'b0, 4'd0);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_sr", sr, 2'b00);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_ready", in_ready, 1);
    chk("t5_rst_shadow", shadow_q, 0);
    @(negedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk); #2;
    push(1'b0, 4'd0);
    @(negedge clk); chk("t5_explicit_reset", sr, 2'b01);
    #2;
    wait_idle(50);
    chk("t5_qfb", q_fb, 0);

    // Random run
    do_reset();
    for (int n = 0; n < 1000; n++) begin
      repeat ($urandom_range(0, 2)) begin @(negedge clk); #2; end
      push(1'($urandom_range(0, 1)), HOLD_W'($urandom_range(0, 3)));
    end
    wait_idle(200);
    chk("rand_err", err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sr_cmd_driver.md
# sr_cmd_driver

Transmit-side companion to the SR flip-flop. It accepts a stream of target-bit commands over a valid/ready handshake and drives the 2-bit `sr` excitation into a downstream SR flip-flop. It keeps a shadow copy of the flip-flop state and checks the flip-flop's `q` feedback against the commanded value. It never issues the illegal `11` code.

## Interface
- `HOLD_W`, default 4: width of the per-command hold count.
- `DEPTH`, default 4: command FIFO depth; must be a power of two, ≥2.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  command present.
- `in_ready`  out  1  FIFO not full; command accepted on an edge where `in_valid & in_ready`.
- `in_target`  in  1  desired flip-flop value.
- `in_hold`  in  HOLD_W  extra cycles to hold and monitor after the check.
- `sr`  out  2  registered excitation: `[1]`=S, `[0]`=R.
- `q_fb`  in  1  `q` returned from the driven flip-flop.
- `shadow_q`  out  1  last commanded value.
- `busy`  out  1  FSM not IDLE or FIFO not empty.
- `err`  out  1  sticky mismatch flag.

## Operation
- FIFO: `DEPTH` entries of {target, hold}.
  - Push on `in_valid & in_ready`.
  - `in_ready` = !full. There is no bypass; a push while full cannot occur.
  - Pop only when the FSM enters APPLY.
  - Push and pop in the same cycle are both honoured; the count is unchanged.
- Shadow state: `shadow_q` and an internal `known` bit. `known`=0 after reset.
- Excitation chosen in APPLY:
  - `known`=0: always explicit; SET (`10`) if target=1, RESET (`01`) if target=0.
  - `known`=1, target ≠ `shadow_q`: SET or RESET accordingly.
  - `known`=1, target = `shadow_q`: HOLD (`00`).
  - On leaving APPLY: `shadow_q` ← target, `known` ← 1.
- FSM states:
  - IDLE: `sr`=00. If FIFO non-empty, pop and go to APPLY.
  - APPLY (1 cycle): `sr` = chosen code. Go to CHECK.
  - CHECK (1 cycle): `sr`=00. At the closing edge, compare `q_fb` with `shadow_q`; a mismatch sets `err`.
    - If hold>0, load the counter with hold and go to HOLD.
    - Else, if FIFO non-empty, pop and go to APPLY; otherwise go to IDLE.
  - HOLD: `sr`=00. Compare `q_fb` every cycle; decrement the counter. At 1, leave with the same exit rule as CHECK.
- `sr`=11 is never driven in any state.
- `err` stays set until reset. There is no software clear.
- Reset values: `sr`=00, `shadow_q`=0, `known`=0, `err`=0, `busy`=0, `in_ready`=1, FIFO empty, FSM IDLE.
- Reset mid-operation: everything returns to reset values immediately and the FIFO contents are discarded.

## Timing
- Command accepted at edge e with FIFO empty and FSM IDLE:
  - Pop at e+1.
  - `sr` shows the excitation from e+1 to e+2.
  - The flip-flop updates at e+2.
  - `q_fb` is compared at e+3 (end of CHECK).
- Per-command occupancy is 2 + hold cycles.
- Back-to-back commands incur no IDLE bubble.
- Sustained throughput with hold=0 is one command per 2 cycles.
- `busy` falls on the edge where the FSM returns to IDLE with the FIFO empty.
- `q_fb` is not compared while in IDLE or APPLY.

## Structure
- Package `sr_pkg`:
  - Constants `SR_HOLD`=2'b00, `SR_RESET`=2'b01, `SR_SET`=2'b10, `SR_ILLEGAL`=2'b11.
  - FSM state encoding IDLE/APPLY/CHECK/HOLD.
- Sub-module `sr_cmd_fifo`: synchronous FIFO, parameterised width and depth. It provides full, empty, push and pop, and uses the same `clk`/`rst_n`.
- The top level contains the FSM, shadow logic, hold counter and `err`.
- The bench connects the top level to the existing SR flip-flop through `sr` and `q`.

## Test plan
- Reset, then push {1,0}: `sr`=10 for exactly one cycle one edge after acceptance; `q_fb`=1; `err`=0; `busy` low 2 cycles after the pop.
- Push {1,0}, {1,0}, {0,2} back-to-back: `sr` sequence is 10,00,00,00,01,00,00,00. The second command emits HOLD because it is already known. `shadow_q` ends at 0.
- Push 6 commands while the FSM is stalled in a long hold (hold=15): `in_ready` drops after 4 are accepted and rises one cycle after the next pop. No command is lost or duplicated.
- Force `q_fb`=0 (stuck) and push {1,3}: `err` rises at the end of CHECK and stays 1 through IDLE until reset.
- Assert `rst_n`=0 during HOLD with 3 commands queued: `sr`=00 and `busy`=0 immediately. After release, push {0,0}: `sr`=01, an explicit reset because `known` was cleared.
- Random 1000-command run: assert `sr` is never 11 and `q_fb` equals `shadow_q` in every CHECK/HOLD cycle.
